// File: rtl/core_wback_arb.sv
// ---------------------------------------------------------------------------
// core_wback_arb : NCH-channel writeback buffer, round-robin RF port arbiter
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module core_wback_arb #(
   parameter int NCH     = 3,
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5,
   parameter int CNT_W   = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [NCH-1:0]                ch_valid,
   output logic [NCH-1:0]                ch_ready,
   input  logic [NCH-1:0]                ch_wen,
   input  logic [NCH-1:0][RADDR_W-1:0]   ch_rd,
   input  logic [NCH-1:0][XLEN-1:0]      ch_wdata,
   output logic                          rf_wen,
   output logic [RADDR_W-1:0]            rf_waddr,
   output logic [XLEN-1:0]               rf_wdata,
   output logic [CNT_W-1:0]              retire_cnt,
   output logic                          busy
);

   localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]                full;
   logic [NCH-1:0]                ent_wen;
   logic [NCH-1:0][RADDR_W-1:0]   ent_rd;
   logic [NCH-1:0][XLEN-1:0]      ent_data;
   logic [PTR_W-1:0]              rr_ptr;

   logic [NCH-1:0]                writing;
   logic [NCH-1:0]                discard;
   logic [NCH-1:0]                grant_oh;
   logic [NCH-1:0]                drain;
   logic [NCH-1:0]                accept;
   logic                          gnt_vld;
   logic [PTR_W-1:0]              gnt_idx;
   logic [PTR_W-1:0]              cand;
   logic [CNT_W-1:0]              retire_inc;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         writing[i] = full[i] && ent_wen[i] && (ent_rd[i] != '0);
         discard[i] = full[i] && !(ent_wen[i] && (ent_rd[i] != '0));
      end
   end

   // Search starts one past the last granted channel and wraps.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 1; k <= NCH; k++) begin
         cand = PTR_W'((int'(rr_ptr) + k) % NCH);
         if (!gnt_vld && writing[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_comb begin
      grant_oh = '0;
      if (gnt_vld)
         grant_oh[gnt_idx] = 1'b1;
   end

   // A flush retires every buffered entry, granted or not.
   assign drain    = flush ? full : (grant_oh | discard);
   assign ch_ready = {NCH{rst && !flush}} & (~full | drain);
   assign accept   = ch_valid & ch_ready;

   always_comb begin
      retire_inc = '0;
      for (int i = 0; i < NCH; i++)
         retire_inc = retire_inc + CNT_W'(drain[i]);
   end

   assign rf_wen   = gnt_vld;
   assign rf_waddr = gnt_vld ? ent_rd[gnt_idx]   : '0;
   assign rf_wdata = gnt_vld ? ent_data[gnt_idx] : '0;
   assign busy     = |full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full       <= '0;
         ent_wen    <= '0;
         ent_rd     <= '0;
         ent_data   <= '0;
         rr_ptr     <= PTR_W'(NCH - 1);
         retire_cnt <= '0;
      end else begin
         full       <= (full & ~drain) | accept;
         retire_cnt <= retire_cnt + retire_inc;
         if (gnt_vld)
            rr_ptr <= gnt_idx;
         for (int i = 0; i < NCH; i++) begin
            if (accept[i]) begin
               ent_wen[i]  <= ch_wen[i];
               ent_rd[i]   <= ch_rd[i];
               ent_data[i] <= ch_wdata[i];
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_core_wback_arb.sv
// Randomized and directed self-checking bench for core_wback_arb (NCH=3, CNT_W=4).
`default_nettype none

module tb_core_wback_arb;

   localparam int NCH = 3;
   localparam int XLEN = 32;
   localparam int RW = 5;
   localparam int CW = 4;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    flush = 1'b0;
   logic [NCH-1:0]          ch_valid = '0;
   logic [NCH-1:0]          ch_ready;
   logic [NCH-1:0]          ch_wen = '0;
   logic [NCH-1:0][RW-1:0]  ch_rd = '0;
   logic [NCH-1:0][XLEN-1:0] ch_wdata = '0;
   logic                    rf_wen;
   logic [RW-1:0]           rf_waddr;
   logic [XLEN-1:0]         rf_wdata;
   logic [CW-1:0]           retire_cnt;
   logic                    busy;

   core_wback_arb #(.NCH(NCH), .XLEN(XLEN), .RADDR_W(RW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_wen(ch_wen),
      .ch_rd(ch_rd), .ch_wdata(ch_wdata),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .retire_cnt(retire_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: buffered results per channel, last granted channel, retire tally.
   bit        m_full [NCH];
   bit        m_wen  [NCH];
   int        m_rd   [NCH];
   int unsigned m_data [NCH];
   int        m_last;
   int        m_cnt;

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) m_full[i] = 0;
      m_last = NCH - 1;
      m_cnt  = 0;
   endtask

   function automatic bit m_writes(int i);
      return m_full[i] && m_wen[i] && (m_rd[i] != 0);
   endfunction

   function automatic int m_grant();
      for (int k = 1; k <= NCH; k++) begin
         if (m_writes((m_last + k) % NCH)) return (m_last + k) % NCH;
      end
      return -1;
   endfunction

   function automatic bit m_leaves(int i, int g, bit f);
      if (f) return m_full[i];
      return m_full[i] && ((i == g) || !m_writes(i));
   endfunction

   task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] w,
                       input logic [NCH-1:0][RW-1:0] r, input logic [NCH-1:0][XLEN-1:0] d,
                       input logic f);
      int g;
      logic [NCH-1:0] rdy;
      bit any;
      @(negedge clk);
      ch_valid = v; ch_wen = w; ch_rd = r; ch_wdata = d; flush = f;
      #1;
      g = m_grant();
      any = 0;
      for (int i = 0; i < NCH; i++) begin
         rdy[i] = !f && (!m_full[i] || m_leaves(i, g, 1'b0));
         any |= m_full[i];
      end
      check("rf_wen", 64'(rf_wen), 64'(g >= 0));
      check("rf_waddr", 64'(rf_waddr), (g >= 0) ? 64'(m_rd[g]) : 64'd0);
      check("rf_wdata", 64'(rf_wdata), (g >= 0) ? 64'(m_data[g]) : 64'd0);
      check("ch_ready", 64'(ch_ready), 64'(rdy));
      check("busy", 64'(busy), 64'(any));
      check("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
      @(posedge clk);
      for (int i = 0; i < NCH; i++) begin
         if (m_leaves(i, g, f)) begin
            m_full[i] = 0;
            m_cnt = (m_cnt + 1) % (1 << CW);
         end
         if (v[i] && rdy[i]) begin
            m_full[i] = 1; m_wen[i] = w[i]; m_rd[i] = int'(r[i]); m_data[i] = d[i];
         end
      end
      if (g >= 0) m_last = g;
      #1;
   endtask

   task automatic idle();
      step('0, '0, '0, '0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; ch_valid = '0; flush = 1'b0;
      #1;
      model_reset();
      check("rst_rf_wen", 64'(rf_wen), 64'd0);
      check("rst_retire", 64'(retire_cnt), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ready", 64'(ch_ready), 64'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   logic [NCH-1:0][RW-1:0]   rd_v;
   logic [NCH-1:0][XLEN-1:0] dt_v;

   initial begin
      model_reset();
      #2;
      check("por_rf_wen", 64'(rf_wen), 64'd0);
      check("por_rf_waddr", 64'(rf_waddr), 64'd0);
      check("por_rf_wdata", 64'(rf_wdata), 64'd0);
      check("por_ready", 64'(ch_ready), 64'd0);
      do_reset();
      idle();
      check("ready_after_rst", 64'(ch_ready), 64'h7);

      // Single channel, then back-to-back on ch0.
      rd_v = '0; dt_v = '0; rd_v[0] = 5'd5; dt_v[0] = 32'hDEADBEEF;
      step(3'b001, 3'b001, rd_v, dt_v, 1'b0);
      check("single_wen", 64'(rf_wen), 64'd1);
      check("single_addr", 64'(rf_waddr), 64'd5);
      check("single_data", 64'(rf_wdata), 64'hDEADBEEF);
      for (int n = 0; n < 4; n++) begin
         rd_v[0] = RW'(n + 8); dt_v[0] = 32'(n * 3 + 1);
         step(3'b001, 3'b001, rd_v, dt_v, 1'b0);
         check("b2b_addr", 64'(rf_waddr), 64'(n + 8));
      end
      idle();
      idle();
      check("single_retire", 64'(retire_cnt), 64'd5);

      // Contention after reset: ch0, ch1, ch2 in order, ch0 refilled.
      do_reset();
      rd_v[0] = 5'd1; rd_v[1] = 5'd2; rd_v[2] = 5'd3;
      dt_v[0] = 32'h11; dt_v[1] = 32'h22; dt_v[2] = 32'h33;
      step(3'b111, 3'b111, rd_v, dt_v, 1'b0);
      check("cont_g0", 64'(rf_waddr), 64'd1);
      for (int n = 0; n < 6; n++) step(3'b001, 3'b001, rd_v, dt_v, 1'b0);
      idle(); idle(); idle();

      // Discard alongside a writing entry.
      rd_v[0] = 5'd7; rd_v[1] = 5'd0;
      step(3'b011, 3'b011, rd_v, dt_v, 1'b0);
      check("disc_addr", 64'(rf_waddr), 64'd7);
      idle();

      // Flush with ch1 granted and ch2 pending.
      rd_v[1] = 5'd9; rd_v[2] = 5'd10;
      step(3'b110, 3'b110, rd_v, dt_v, 1'b0);
      check("flush_pre_addr", 64'(rf_waddr), 64'd9);
      step(3'b111, 3'b111, rd_v, dt_v, 1'b1);
      check("flush_busy", 64'(busy), 64'd0);
      idle();

      // Reset mid-operation, then ch0 first.
      rd_v[0] = 5'd4; rd_v[1] = 5'd5; rd_v[2] = 5'd6;
      step(3'b111, 3'b111, rd_v, dt_v, 1'b0);
      do_reset();
      step(3'b111, 3'b111, rd_v, dt_v, 1'b0);
      check("post_rst_first", 64'(rf_waddr), 64'd4);
      idle(); idle(); idle();

      // Counter wrap: 17 discards retire on a 4-bit counter.
      do_reset();
      for (int n = 0; n < 17; n++) step(3'b001, 3'b000, rd_v, dt_v, 1'b0);
      idle();
      check("wrap_cnt", 64'(retire_cnt), 64'd1);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NCH; i++) begin
            rd_v[i] = RW'($urandom_range(0, 31));
            dt_v[i] = $urandom;
         end
         step(NCH'($urandom), NCH'($urandom), rd_v, dt_v, ($urandom_range(0, 11) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
